chart_sequencer: RTL and testbench

- Upstream feeder for pattern_manager.
- Holds a rhythm chart in an internal RAM. Each chart entry is 18 bits: timestamp in [17:8] and 8-bit note pattern in [7:0].
- Drives pattern_with_timestamp with the next upcoming entry and advances as the game clock (counter10h) passes each timestamp.
- The chart is loaded through a write port while the block is idle. Play is started by a pulse.

---
 rtl/chart_sequencer.sv | 160 ++++++++++++++++
 tb/tb_chart_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/chart_sequencer.sv
// Rhythm-chart feeder for pattern_manager: presents the next upcoming chart entry.
// Latency: first entry 2 clocks after start; each advance takes 2 clocks (FETCH then load).
// Backpressure: none; pacing comes only from counter10h passing each entry timestamp.
//
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   start                   one-cycle pulse, (re)start playback from entry 0
//   counter10h              game time from game_clock
//   chart_len               number of valid entries, sampled on start (clamped to DEPTH)
//   wr_en/wr_addr/wr_data   chart RAM write port, honoured only in IDLE and DONE
//   pattern_with_timestamp  {timestamp[9:0], pattern[7:0]} of the presented entry
//   entry_valid             presented entry is a real chart entry
//   entry_index             index of the presented entry
//   done                    chart exhausted or game time wrapped
module chart_sequencer #(
  parameter int          ADDR_W = 6,
  parameter int          DEPTH  = 64,
  parameter logic [9:0]  END_TS = 10'h3FF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [9:0]        counter10h,
  input  logic [ADDR_W:0]   chart_len,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [17:0]       wr_data,
  output logic [17:0]       pattern_with_timestamp,
  output logic              entry_valid,
  output logic [ADDR_W-1:0] entry_index,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, PRIME, FETCH, WAIT, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L    = (ADDR_W+1)'(1);
  localparam logic [17:0]     END_WORD = {END_TS, 8'h00};

  state_t            state, state_d;
  logic [ADDR_W:0]   len, len_d;
  logic [9:0]        last_counter;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en;
  logic [17:0]       rd_data;
  logic [17:0]       mem [DEPTH];

  logic [17:0]       pwt_d;
  logic              vld_d;
  logic [ADDR_W-1:0] idx_d;
  logic              done_d;

  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W:0]   next_idx;
  logic              in_play;
  logic              wrap;
  logic              advance;
  logic              wr_ok;

  assign len_clamped = (chart_len > DEPTH_L) ? DEPTH_L : chart_len;
  assign next_idx    = {1'b0, entry_index} + ONE_L;
  assign in_play     = (state == PRIME) || (state == FETCH) || (state == WAIT);
  // Time going backwards means either a 10-bit wrap or a game_clock reset.
  assign wrap        = counter10h < last_counter;
  // Strict compare keeps the entry visible through the tick equal to its timestamp.
  assign advance     = counter10h > pattern_with_timestamp[17:8];
  // Chart may only be rewritten while nothing is reading it.
  assign wr_ok       = wr_en && ((state == IDLE) || (state == DONE));

  // Outputs are computed here as next values and registered below, so no
  // input reaches an output combinationally.
  always_comb begin
    state_d   = state;
    len_d     = len;
    rd_en     = 1'b0;
    rd_addr_d = rd_addr_q;
    pwt_d     = pattern_with_timestamp;
    vld_d     = entry_valid;
    idx_d     = entry_index;
    done_d    = done;

    if (start) begin
      // Restart wins over wrap and advance from any state.
      len_d  = len_clamped;
      done_d = 1'b0;
      if (len_clamped == '0) begin
        state_d = DONE;
        pwt_d   = END_WORD;
        vld_d   = 1'b0;
        done_d  = 1'b1;
      end else begin
        rd_en     = 1'b1;
        rd_addr_d = '0;
        state_d   = PRIME;
      end
    end else if (in_play && wrap) begin
      state_d = DONE;
      pwt_d   = END_WORD;
      vld_d   = 1'b0;
      done_d  = 1'b1;
    end else begin
      case (state)
        PRIME, FETCH: begin
          pwt_d   = rd_data;
          vld_d   = 1'b1;
          idx_d   = rd_addr_q;
          state_d = WAIT;
        end
        WAIT: begin
          if (advance) begin
            if (next_idx < len) begin
              rd_en     = 1'b1;
              rd_addr_d = next_idx[ADDR_W-1:0];
              state_d   = FETCH;
            end else begin
              state_d = DONE;
              pwt_d   = END_WORD;
              vld_d   = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= IDLE;
      len                    <= '0;
      last_counter           <= '0;
      rd_addr_q              <= '0;
      pattern_with_timestamp <= END_WORD;
      entry_valid            <= 1'b0;
      entry_index            <= '0;
      done                   <= 1'b0;
    end else begin
      state                  <= state_d;
      len                    <= len_d;
      last_counter           <= counter10h;
      rd_addr_q              <= rd_addr_d;
      pattern_with_timestamp <= pwt_d;
      entry_valid            <= vld_d;
      entry_index            <= idx_d;
      done                   <= done_d;
    end
  end

  // Chart RAM: contents survive reset; read data lands one clock after rd_en.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr_d];
    end
  end

endmodule

// File: tb/tb_chart_sequencer.sv
module tb_chart_sequencer;

  localparam logic [17:0] ENDW = {10'h3FF, 8'h00};

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [9:0]  counter10h;
  logic [6:0]  chart_len;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [17:0] wr_data;
  logic [17:0] pattern_with_timestamp;
  logic        entry_valid;
  logic [5:0]  entry_index;
  logic        done;

  chart_sequencer dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .start                  (start),
    .counter10h             (counter10h),
    .chart_len              (chart_len),
    .wr_en                  (wr_en),
    .wr_addr                (wr_addr),
    .wr_data                (wr_data),
    .pattern_with_timestamp (pattern_with_timestamp),
    .entry_valid            (entry_valid),
    .entry_index            (entry_index),
    .done                   (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: expected output word {pwt, valid, index, done} and the cycle
  // at which the outputs must change to it (-1 = any cycle).
  logic [25:0] exp_q[$];
  int          exp_cyc_q[$];
  string       exp_nm_q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          s;

  task automatic push(input string nm, input logic [17:0] p, input logic v,
                      input logic [5:0] i, input logic d, input int c);
    exp_q.push_back({p, v, i, d});
    exp_cyc_q.push_back(c);
    exp_nm_q.push_back(nm);
  endtask

  // Monitor: every change of the output bundle is one presented response.
  logic [25:0] prev;
  logic [25:0] cur;
  always @(negedge clock) begin
    cur = {pattern_with_timestamp, entry_valid, entry_index, done};
    if (cur !== prev) begin
      prev = cur;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_change got=%h at cyc %0d, no response expected", cur, cyc);
      end else begin
        logic [25:0] e;
        int          ec;
        string       nm;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        nm = exp_nm_q.pop_front();
        if (cur !== e || (ec >= 0 && ec != cyc)) begin
          mismatched++;
          $display("FAIL %s got=%h at cyc %0d, want=%h at cyc %0d", nm, cur, cyc, e, ec);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [17:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick(1);
    wr_en   = 1'b0;
  endtask

  task automatic do_start(input logic [6:0] l);
    chart_len = l;
    start     = 1'b1;
    s         = cyc;
    tick(1);
    start     = 1'b0;
  endtask

  int c;

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    counter10h = '0;
    chart_len  = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    push("reset_state", ENDW, 1'b0, 6'd0, 1'b0, -1);
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // Basic play plus the equal-timestamp boundary tick.
    wr(6'd0, {10'd10, 8'h01});
    wr(6'd1, {10'd20, 8'h82});
    wr(6'd2, {10'd30, 8'hFF});
    do_start(7'd3);
    push("basic_e0", {10'd10, 8'h01}, 1'b1, 6'd0, 1'b0, s + 2);
    tick(3);
    counter10h = 10'd10;
    tick(4);
    counter10h = 10'd11;
    c = cyc;
    push("boundary_adv_e1", {10'd20, 8'h82}, 1'b1, 6'd1, 1'b0, c + 2);
    tick(4);
    counter10h = 10'd31;
    c = cyc;
    push("basic_e2", {10'd30, 8'hFF}, 1'b1, 6'd2, 1'b0, c + 2);
    push("basic_done", ENDW, 1'b0, 6'd2, 1'b1, c + 3);
    tick(5);

    // Restart from DONE, then restarts mid-play.
    counter10h = 10'd0;
    tick(2);
    do_start(7'd3);
    push("restart_done_clr", ENDW, 1'b0, 6'd2, 1'b0, s + 1);
    push("restart_e0", {10'd10, 8'h01}, 1'b1, 6'd0, 1'b0, s + 2);
    tick(3);
    counter10h = 10'd25;
    c = cyc;
    push("run_e1", {10'd20, 8'h82}, 1'b1, 6'd1, 1'b0, c + 2);
    push("run_e2", {10'd30, 8'hFF}, 1'b1, 6'd2, 1'b0, c + 4);
    tick(6);
    do_start(7'd3);
    push("midplay_e0", {10'd10, 8'h01}, 1'b1, 6'd0, 1'b0, s + 2);
    push("midplay_e1", {10'd20, 8'h82}, 1'b1, 6'd1, 1'b0, s + 4);
    push("midplay_e2", {10'd30, 8'hFF}, 1'b1, 6'd2, 1'b0, s + 6);
    tick(8);
    counter10h = 10'd31;
    do_start(7'd3);
    push("start_vs_adv_e0", {10'd10, 8'h01}, 1'b1, 6'd0, 1'b0, s + 2);
    push("start_vs_adv_e1", {10'd20, 8'h82}, 1'b1, 6'd1, 1'b0, s + 4);
    push("start_vs_adv_e2", {10'd30, 8'hFF}, 1'b1, 6'd2, 1'b0, s + 6);
    push("start_vs_adv_done", ENDW, 1'b0, 6'd2, 1'b1, s + 7);
    tick(10);

    // Catch-up over entries already in the past.
    wr(6'd0, {10'd5, 8'hA0});
    wr(6'd1, {10'd6, 8'hA1});
    wr(6'd2, {10'd7, 8'hA2});
    wr(6'd3, {10'd50, 8'hA3});
    counter10h = 10'd40;
    do_start(7'd4);
    push("catchup_clr", ENDW, 1'b0, 6'd2, 1'b0, s + 1);
    push("catchup_e0", {10'd5, 8'hA0}, 1'b1, 6'd0, 1'b0, s + 2);
    push("catchup_e1", {10'd6, 8'hA1}, 1'b1, 6'd1, 1'b0, s + 4);
    push("catchup_e2", {10'd7, 8'hA2}, 1'b1, 6'd2, 1'b0, s + 6);
    push("catchup_e3", {10'd50, 8'hA3}, 1'b1, 6'd3, 1'b0, s + 8);
    tick(10);

    // Write while in WAIT must be ignored; reset mid-WAIT is immediate.
    wr(6'd0, {10'd0, 8'hEE});
    push("reset_midwait", ENDW, 1'b0, 6'd0, 1'b0, cyc);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    counter10h = 10'd0;
    tick(2);
    do_start(7'd4);
    push("ram_kept_e0", {10'd5, 8'hA0}, 1'b1, 6'd0, 1'b0, s + 2);
    tick(3);

    // len==0 finishes with no valid entry.
    do_start(7'd0);
    push("len0_done", ENDW, 1'b0, 6'd0, 1'b1, s + 1);
    tick(3);

    // Wrap 1023 -> 0 during WAIT.
    wr(6'd0, {10'h3FF, 8'h5A});
    do_start(7'd1);
    push("wrap_clr", ENDW, 1'b0, 6'd0, 1'b0, s + 1);
    push("wrap_e0", {10'h3FF, 8'h5A}, 1'b1, 6'd0, 1'b0, s + 2);
    tick(3);
    counter10h = 10'd1023;
    tick(4);
    counter10h = 10'd0;
    c = cyc;
    push("wrap_done", ENDW, 1'b0, 6'd0, 1'b1, c + 1);
    tick(3);

    // chart_len above DEPTH plays exactly DEPTH entries.
    for (int i = 0; i < 64; i++) begin
      wr(6'(i), {10'(i), 8'(i)});
    end
    counter10h = 10'd1000;
    do_start(7'd100);
    push("clamp_clr", ENDW, 1'b0, 6'd0, 1'b0, s + 1);
    for (int i = 0; i < 64; i++) begin
      push("clamp_entry", {10'(i), 8'(i)}, 1'b1, 6'(i), 1'b0, s + 2 + 2 * i);
    end
    push("clamp_done", ENDW, 1'b0, 6'd63, 1'b1, s + 129);
    tick(140);

    while (exp_q.size() != 0) begin
      string nm;
      nm = exp_nm_q.pop_front();
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
      compared++;
      mismatched++;
      $display("FAIL %s got=no response, want=a response before cyc %0d", nm, cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
